pipe_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline registers (F/D/E/M/W enable+clear flops).

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_det.sv | 38 +++
 rtl/pipe_stall_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared FSM encoding and constants for the pipeline stall controller
package pipe_ctrl_pkg;

  // Divider handshake sequencer states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  // Architectural zero register: writes to it are discarded, so it never carries a dependency
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipe_hazard_det.sv
// rtl/pipe_hazard_det.sv - load-use and branch-operand hazard detect (combinational)
import pipe_ctrl_pkg::*;

module pipe_hazard_det #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              memtoregM,
  output logic              hazard_stall
);

  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(REG_ZERO);

  logic e_hit;
  logic m_hit;
  logic load_use;
  logic branch_dep;

  // E writes a nonzero register that D reads
  assign e_hit = regwriteE && (writeregE != ZERO_REG) &&
                 ((writeregE == rsD) || (writeregE == rtD));

  // M holds a load whose data is not yet forwardable to the D-stage comparator
  assign m_hit = memtoregM && (writeregM != ZERO_REG) &&
                 ((writeregM == rsD) || (writeregM == rtD));

  // A load in E cannot forward to E in time; a branch in D compares before any forward arrives
  assign load_use     = memtoregE && e_hit;
  assign branch_dep   = branchD && (e_hit || m_hit);
  assign hazard_stall = load_use || branch_dep;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush sequencer with divider handshake; PIPE_CTRL_PERF_EN adds perf counters
import pipe_ctrl_pkg::*;

module pipe_stall_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              memtoregM,
  input  logic              div_opE,
  input  logic              div_ready,
  input  logic              i_stall,
  input  logic              d_stall,
  input  logic              exceptM,
  output logic              div_start,
  output logic              div_abort,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
`ifdef PIPE_CTRL_PERF_EN
  output logic              flushW,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
`else
  output logic              flushW
`endif
);

  if (CNT_W < 1 || REG_AW < 1) begin : g_bad_param
    $error("pipe_stall_ctrl: CNT_W and REG_AW must be at least 1");
  end

  state_t state;
  state_t next_state;
  logic   hazard_stall;
  logic   mem_stall;
  logic   exc_flush;

  pipe_hazard_det #(.REG_AW(REG_AW)) u_hazard (
    .rsD          (rsD),
    .rtD          (rtD),
    .branchD      (branchD),
    .writeregE    (writeregE),
    .regwriteE    (regwriteE),
    .memtoregE    (memtoregE),
    .writeregM    (writeregM),
    .memtoregM    (memtoregM),
    .hazard_stall (hazard_stall)
  );

  assign mem_stall = i_stall || d_stall;
  // An exception held behind a memory stall is acted on only once the stall drops (M is frozen)
  assign exc_flush = rst && !mem_stall && exceptM;

  // Priority mux: memory stall > exception > divider > data hazard; everything quiet in reset
  always_comb begin
    next_state = state;
    div_start  = 1'b0;
    div_abort  = 1'b0;
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    stallM     = 1'b0;
    stallW     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushM     = 1'b0;
    flushW     = 1'b0;
    if (!rst) begin
      next_state = RUN;
    end else if (mem_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      stallW = 1'b1;
    end else if (exceptM) begin
      flushD     = 1'b1;
      flushE     = 1'b1;
      flushM     = 1'b1;
      flushW     = 1'b1;
      div_abort  = (state == DIV_WAIT);
      next_state = RUN;
    end else begin
      case (state)
        RUN: begin
          if (div_opE) begin
            div_start  = 1'b1;
            stallF     = 1'b1;
            stallD     = 1'b1;
            stallE     = 1'b1;
            flushM     = 1'b1;
            next_state = DIV_WAIT;
          end else if (hazard_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
          end
        end
        DIV_WAIT: begin
          // E is frozen on the divide, so data hazards are moot and E must not be bubbled
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          flushM = 1'b1;
          if (div_ready) next_state = DIV_DONE;
        end
        DIV_DONE: begin
          // div_opE is still high here as the finished divide leaves E; do not restart it
          if (hazard_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
          end
          next_state = RUN;
        end
        default: next_state = RUN;
      endcase
    end
  end

  // Divider handshake state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= next_state;
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating counters of fetch-stall cycles and exception flushes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stallF && (perf_stall_cnt != {CNT_W{1'b1}}))
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (exc_flush && (perf_flush_cnt != {CNT_W{1'b1}}))
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_exc_flush;
  assign unused_exc_flush = exc_flush;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  // Output vector order: {div_start, div_abort, stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW}
  localparam logic [10:0] IDLE = 11'b00_00000_0000;
  localparam logic [10:0] LU   = 11'b00_11000_0100;
  localparam logic [10:0] DIVS = 11'b10_11100_0010;
  localparam logic [10:0] DIVW = 11'b00_11100_0010;
  localparam logic [10:0] MEM  = 11'b00_11111_0000;
  localparam logic [10:0] EXC  = 11'b00_00000_1111;
  localparam logic [10:0] EXCA = 11'b01_00000_1111;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] rsD, rtD, writeregE, writeregM;
  logic              branchD, regwriteE, memtoregE, memtoregM;
  logic              div_opE, div_ready, i_stall, d_stall, exceptM;
  logic              div_start, div_abort;
  logic              stallF, stallD, stallE, stallM, stallW;
  logic              flushD, flushE, flushM, flushW;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0]  perf_stall_cnt, perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_stall_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .rsD            (rsD),
    .rtD            (rtD),
    .branchD        (branchD),
    .writeregE      (writeregE),
    .regwriteE      (regwriteE),
    .memtoregE      (memtoregE),
    .writeregM      (writeregM),
    .memtoregM      (memtoregM),
    .div_opE        (div_opE),
    .div_ready      (div_ready),
    .i_stall        (i_stall),
    .d_stall        (d_stall),
    .exceptM        (exceptM),
    .div_start      (div_start),
    .div_abort      (div_abort),
    .stallF         (stallF),
    .stallD         (stallD),
    .stallE         (stallE),
    .stallM         (stallM),
    .stallW         (stallW),
    .flushD         (flushD),
    .flushE         (flushE),
    .flushM         (flushM),
`ifdef PIPE_CTRL_PERF_EN
    .flushW         (flushW),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`else
    .flushW         (flushW)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {div_start, div_abort, stallF, stallD, stallE, stallM, stallW,
            flushD, flushE, flushM, flushW};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs were set just after a falling edge; check mid-low-phase, then move to the next falling edge
  task automatic cyc(input string tag, input logic [10:0] exp);
    #2;
    check(tag, 32'(outs()), 32'(exp));
    @(negedge clk);
  endtask

  task automatic quiet();
    rsD = 5'd1; rtD = 5'd2; branchD = 0;
    writeregE = 5'd0; regwriteE = 0; memtoregE = 0;
    writeregM = 5'd0; memtoregM = 0;
    div_opE = 0; div_ready = 0; i_stall = 0; d_stall = 0; exceptM = 0;
  endtask

  initial begin
    quiet();
    rst = 1'b0;
    // reset: outputs low even with stall/divide requests present
    i_stall = 1; div_opE = 1; exceptM = 1;
    @(negedge clk);
    cyc("reset_outs", IDLE);
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall_rst", 32'(perf_stall_cnt), 32'd0);
    check("perf_flush_rst", 32'(perf_flush_cnt), 32'd0);
`endif
    quiet();
    rst = 1'b1;
    cyc("idle_run", IDLE);

    // load-use on rt, then the bubble has left E
    memtoregE = 1; regwriteE = 1; writeregE = 5'd3; rtD = 5'd3;
    cyc("lu_rt", LU);
    quiet();
    cyc("lu_after", IDLE);
    memtoregE = 1; regwriteE = 1; writeregE = 5'd4; rsD = 5'd4;
    cyc("lu_rs", LU);
    quiet();
    memtoregE = 1; regwriteE = 1; writeregE = 5'd0; rsD = 5'd0;
    cyc("lu_zero", IDLE);
    quiet();
    regwriteE = 1; writeregE = 5'd3; rtD = 5'd3;
    cyc("alu_no_branch", IDLE);

    // branch operand hazards
    quiet();
    branchD = 1; rsD = 5'd5; regwriteE = 1; writeregE = 5'd5;
    cyc("br_e_alu", LU);
    quiet();
    branchD = 1; rsD = 5'd5; memtoregM = 1; writeregM = 5'd5;
    cyc("br_m_load", LU);
    quiet();
    branchD = 1; rsD = 5'd0; regwriteE = 1; writeregE = 5'd0; memtoregM = 1; writeregM = 5'd0;
    cyc("br_zero", IDLE);

    // div_ready outside DIV_WAIT is ignored
    quiet();
    div_ready = 1;
    cyc("stray_ready", IDLE);
    div_ready = 0;
    cyc("stray_ready_after", IDLE);

    // divide: ready after 4 wait cycles, hazard suppressed during wait
    div_opE = 1;
    cyc("div_c0", DIVS);
    cyc("div_c1", DIVW);
    memtoregE = 1; regwriteE = 1; writeregE = 5'd3; rtD = 5'd3;
    cyc("div_c2_hazard", DIVW);
    quiet(); div_opE = 1;
    cyc("div_c3", DIVW);
    div_ready = 1;
    cyc("div_c4", DIVW);
    div_ready = 0;
    cyc("div_done", IDLE);
    div_opE = 0;
    cyc("div_run", IDLE);

    // exception while waiting on the divider
    div_opE = 1;
    cyc("exc_div_c0", DIVS);
    cyc("exc_div_c1", DIVW);
    exceptM = 1;
    cyc("exc_abort", EXCA);
    quiet();
    cyc("exc_after", IDLE);

    // exception outranks a new divide in RUN
    div_opE = 1; exceptM = 1;
    cyc("exc_over_div", EXC);
    quiet();
    cyc("exc_over_div_after", IDLE);

    // data stall holds a pending exception for three cycles
    d_stall = 1; exceptM = 1;
    cyc("dstall_1", MEM);
    cyc("dstall_2", MEM);
    cyc("dstall_3", MEM);
    d_stall = 0;
    cyc("dstall_exc", EXC);
    quiet();

    // fetch stall during DIV_WAIT holds the FSM
    div_opE = 1;
    cyc("mdiv_c0", DIVS);
    i_stall = 1;
    cyc("mdiv_ist1", MEM);
    cyc("mdiv_ist2", MEM);
    i_stall = 0;
    cyc("mdiv_held", DIVW);
    div_ready = 1;
    cyc("mdiv_ready", DIVW);
    div_ready = 0;
    cyc("mdiv_done", IDLE);
    div_opE = 0;
    cyc("mdiv_run", IDLE);

`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall_sat", 32'(perf_stall_cnt), 32'(4'hF));
    check("perf_flush_cnt", 32'(perf_flush_cnt), 32'd3);
`endif

    // asynchronous reset in DIV_WAIT
    div_opE = 1;
    cyc("rdiv_c0", DIVS);
    #2;
    check("rdiv_wait", 32'(outs()), 32'(DIVW));
    rst = 1'b0;
    #1;
    check("rdiv_async_outs", 32'(outs()), 32'(IDLE));
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall_async", 32'(perf_stall_cnt), 32'd0);
`endif
    @(negedge clk);
    div_opE = 0;
    rst = 1'b1;
    cyc("rdiv_run", IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
